// File: rtl/scr_pkg.sv
// Shared types and constants for the SCREEN$ loader: FSM states, FIFO entry
// layout and the two accepted image lengths.
package scr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scr_state_t;

    localparam int SCR_STD_LEN     = 6912;
    localparam int SCR_HI_LEN      = 12288;
    localparam int SCR_ATTR_BASE   = 6144;
    localparam int SCR_HIATTR_BASE = 8192;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } scr_entry_t;

    // A finished image is only good if it is exactly a standard or a hi-colour screen.
    function automatic logic len_ok(input logic [13:0] n);
        return (n == 14'(SCR_STD_LEN)) || (n == 14'(SCR_HI_LEN));
    endfunction

endpackage

// File: rtl/scr_loader_if.sv
// ioctl download channel plus the VRAM write port, bundled for the loader.
interface scr_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [13:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        vram_we;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, vram_we, vram_waddr, vram_wdata
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, vram_we, vram_waddr, vram_wdata
    );

endinterface

// File: rtl/scr_fifo.sv
// Small synchronous FIFO of {addr, data} entries with a synchronous flush.
// Pushes while full and pops while empty are ignored.
module scr_fifo
    import scr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  scr_entry_t din,
    output scr_entry_t dout,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    scr_entry_t    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/scr_loader.sv
// Streams a SCREEN$ image from the ioctl channel into VRAM, writing only on
// ce_7mn slots the video fetch leaves free.
module scr_loader
    import scr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_LEVEL = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_7mn,
    input  logic        vid_slot,
    input  logic        page_scr,
    scr_loader_if.slave io,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scr_state_t    state, state_nxt;
    logic          dl_q, rise, fall;
    logic          start, accept, in_range, push, drop, finish, issue, stage;
    logic          full, empty;
    logic [CW-1:0] count;
    scr_entry_t    din, head;
    logic [13:0]   nbytes;
    logic          page_q;
    // head_vld: the FIFO head has been copied into the VRAM address/data
    // registers and is waiting for a free slot. The entry is only popped when
    // written, so FIFO occupancy still counts it.
    logic          head_vld;

    assign din  = '{addr: io.ioctl_addr, data: io.ioctl_dout};
    assign rise = io.ioctl_download & ~dl_q;
    assign fall = ~io.ioctl_download & dl_q;

    scr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (start),
        .push    (push),
        .pop     (issue),
        .din     (din),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (rise) state_nxt = LOAD;
            LOAD:       if (fall) state_nxt = DRAIN;
            DRAIN:      if (empty && !head_vld) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == LOAD) || (state == DRAIN);
        start    = rise && ((state == IDLE) || (state == DONE));
        in_range = io.ioctl_addr < 14'(SCR_HI_LEN);
        accept   = (state == LOAD) && io.ioctl_wr;
        push     = accept && in_range && !full;
        drop     = accept && !(in_range && !full);
        finish   = (state == DRAIN) && empty && !head_vld;
        // Reset gating keeps a staged byte from escaping during the reset cycle.
        issue    = ce_7mn && !vid_slot && head_vld && !reset;
        stage    = !head_vld && !empty && !start;
        io.ioctl_wait = (state == LOAD) && (count >= CW'(WAIT_LEVEL));
        io.vram_we    = issue;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q          <= 1'b0;
            nbytes        <= '0;
            page_q        <= 1'b0;
            head_vld      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            io.vram_waddr <= '0;
            io.vram_wdata <= '0;
        end else begin
            dl_q <= io.ioctl_download;
            if (start) begin
                nbytes   <= '0;
                page_q   <= page_scr;
                head_vld <= 1'b0;
                done     <= 1'b0;
                err      <= 1'b0;
            end else begin
                if (push) nbytes <= nbytes + 14'd1;
                if (drop) err <= 1'b1;
                if (finish) begin
                    if (len_ok(nbytes)) done <= 1'b1;
                    else                err  <= 1'b1;
                end
                if (issue) begin
                    head_vld <= 1'b0;
                end else if (stage) begin
                    head_vld      <= 1'b1;
                    io.vram_waddr <= {page_q, head.addr};
                    io.vram_wdata <= head.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_scr_loader.sv
// Randomised bench for scr_loader: a queue-based model of what must reach VRAM
// and when the status flags must read what, checked on every clock.
module tb_scr_loader;

    localparam int DEPTH = 4;
    localparam int WL    = 3;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic ce_7mn = 1'b0;
    logic vid_slot = 1'b0;
    logic page_scr = 1'b0;
    logic busy, done, err;

    scr_loader_if io();

    scr_loader #(.FIFO_DEPTH(DEPTH), .WAIT_LEVEL(WL)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_7mn   (ce_7mn),
        .vid_slot (vid_slot),
        .page_scr (page_scr),
        .io       (io.slave),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [14:0] waddr;
        logic [7:0]  data;
    } wr_t;

    int   total = 0;
    int   bad = 0;
    int   vid_mode = 0;
    wr_t  q[$];
    bit   m_load, m_drain, m_done, m_err, m_page, dl_prev, wait_prev;
    int   m_bytes, n_we, n_wait_rise, stall;
    logic [14:0] last_waddr = '0;
    logic [14:0] hi_waddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ce_7mn every other clock; vid_mode 0 free, 1 = 4 of every 8 ce taken,
    // 2 = random quarter taken, 3 = every ce taken.
    initial begin
        int cyc = 0;
        int ce_idx = 0;
        forever begin
            @(posedge clk_sys); #1;
            cyc++;
            ce_7mn   = (cyc % 2 == 0);
            vid_slot = 1'b0;
            if (ce_7mn) begin
                case (vid_mode)
                    1:       vid_slot = (ce_idx % 8) < 4;
                    2:       vid_slot = ($urandom_range(0, 3) == 0);
                    3:       vid_slot = 1'b1;
                    default: vid_slot = 1'b0;
                endcase
                ce_idx++;
            end
        end
    end

    initial begin
        int s0;
        bit idle_pre, drain_pre, load_pre;
        logic [31:0] exp_a, exp_d;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                chk("we_in_reset", 32'(io.vram_we), 32'd0);
                q.delete();
                m_load = 0; m_drain = 0; m_done = 0; m_err = 0;
                dl_prev = 0; stall = 0; wait_prev = 0; m_bytes = 0;
            end else begin
                s0 = q.size();
                load_pre  = m_load;
                drain_pre = m_drain;
                idle_pre  = !m_load && !m_drain;
                chk("ioctl_wait", 32'(io.ioctl_wait), 32'(load_pre && s0 >= WL));
                chk("busy", 32'(busy), 32'(load_pre || drain_pre));
                chk("done", 32'(done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                if (io.ioctl_wait && !wait_prev) n_wait_rise++;
                wait_prev = io.ioctl_wait;

                if (io.vram_we) begin
                    exp_a = (s0 > 0) ? 32'(q[0].waddr) : 32'hFFFF_FFFF;
                    exp_d = (s0 > 0) ? 32'(q[0].data)  : 32'hFFFF_FFFF;
                    chk("we_free_slot", 32'(ce_7mn && !vid_slot), 32'd1);
                    chk("we_addr", 32'(io.vram_waddr), exp_a);
                    chk("we_data", 32'(io.vram_wdata), exp_d);
                    if (s0 > 0) void'(q.pop_front());
                    n_we++;
                    last_waddr = io.vram_waddr;
                    if (io.vram_waddr[13:0] == 14'h2000) hi_waddr = io.vram_waddr;
                    stall = 0;
                end else if (ce_7mn && !vid_slot && s0 > 0) begin
                    stall++;
                    chk("drain_stall", 32'(stall < 2), 32'd1);
                end

                if (io.ioctl_wr && load_pre) begin
                    if (io.ioctl_addr >= 14'd12288 || s0 >= DEPTH) m_err = 1;
                    else begin
                        q.push_back('{waddr: {m_page, io.ioctl_addr}, data: io.ioctl_dout});
                        m_bytes++;
                    end
                end
                if (drain_pre && s0 == 0) begin
                    m_drain = 0;
                    if (m_bytes == 6912 || m_bytes == 12288) m_done = 1;
                    else m_err = 1;
                end
                if (io.ioctl_download && !dl_prev && (idle_pre || (!load_pre && !drain_pre))) begin
                    m_load = 1; m_done = 0; m_err = 0; m_bytes = 0;
                    m_page = page_scr; q.delete(); stall = 0;
                end else if (!io.ioctl_download && dl_prev && load_pre) begin
                    m_load = 0; m_drain = 1;
                end
                dl_prev = io.ioctl_download;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    task automatic strobe(input int addr, input logic [7:0] d);
        io.ioctl_wr   = 1'b1;
        io.ioctl_addr = 14'(addr);
        io.ioctl_dout = d;
        tick(1);
        io.ioctl_wr = 1'b0;
    endtask

    task automatic start_load(input bit page);
        tick(1);
        page_scr = page;
        io.ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic send(input int base, input int n, input bit honor);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (honor && io.ioctl_wait && guard < 500) begin tick(1); guard++; end
            if (guard >= 500) begin
                chk("wait_bound", 32'(guard), 32'd0);
                return;
            end
            strobe(base + i, 8'($urandom));
            tick($urandom_range(0, 1));
        end
    endtask

    task automatic end_load();
        int guard = 0;
        io.ioctl_download = 1'b0;
        tick(2);
        while (busy && guard < 40000) begin tick(1); guard++; end
        if (guard >= 40000) chk("drain_bound", 32'(guard), 32'd0);
        tick(1);
    endtask

    initial begin
        int base_we, base_rise, guard;
        bit pg;
        io.ioctl_download = 1'b0;
        io.ioctl_wr = 1'b0;
        io.ioctl_addr = '0;
        io.ioctl_dout = '0;
        tick(3);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_waddr", 32'(io.vram_waddr), 32'h0);
        chk("rst_wdata", 32'(io.vram_wdata), 32'h0);
        chk("rst_we", 32'(io.vram_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wait", 32'(io.ioctl_wait), 32'h0);
        tick(1);

        // Out-of-range offset is dropped and flags the load.
        base_we = n_we;
        start_load(1'b0);
        strobe(12288, 8'hA5);
        tick(6);
        chk("oor_err", 32'(err), 32'd1);
        end_load();
        chk("oor_writes", 32'(n_we - base_we), 32'd0);
        chk("oor_done", 32'(done), 32'd0);

        // Overflow: five strobes while video holds every slot.
        vid_mode = 3;
        base_we = n_we;
        start_load(1'b1);
        send(0, 5, 1'b0);
        tick(2);
        chk("ovf_kept", 32'(q.size()), 32'd4);
        chk("ovf_err", 32'(err), 32'd1);
        vid_mode = 0;
        end_load();
        chk("ovf_writes", 32'(n_we - base_we), 32'd4);
        chk("ovf_done", 32'(done), 32'd0);

        // Short image under random contention.
        vid_mode = 2;
        base_we = n_we;
        start_load(1'($urandom));
        send(0, 100, 1'b1);
        end_load();
        chk("short_writes", 32'(n_we - base_we), 32'd100);
        chk("short_err", 32'(err), 32'd1);
        chk("short_done", 32'(done), 32'd0);

        // Reset with three bytes queued.
        vid_mode = 0;
        start_load(1'b0);
        send(0, 47, 1'b1);
        guard = 0;
        while (q.size() != 0 && guard < 1000) begin tick(1); guard++; end
        vid_mode = 3;
        tick(1);
        send(47, 3, 1'b1);
        tick(2);
        chk("rst_queued", 32'(q.size()), 32'd3);
        reset = 1'b1;
        io.ioctl_download = 1'b0;
        tick(2);
        reset = 1'b0;
        vid_mode = 0;
        base_we = n_we;
        tick(20);
        chk("rst_no_write", 32'(n_we - base_we), 32'd0);
        chk("rst_busy2", 32'(busy), 32'd0);
        chk("rst_wait2", 32'(io.ioctl_wait), 32'd0);

        // Standard screen to page 1, free bus.
        base_we = n_we;
        start_load(1'b1);
        send(0, 6912, 1'b1);
        end_load();
        chk("std_writes", 32'(n_we - base_we), 32'd6912);
        chk("std_last", 32'(last_waddr), 32'h5AFF);
        chk("std_done", 32'(done), 32'd1);
        chk("std_err", 32'(err), 32'd0);

        // Standard screen with fetch taking half the slots.
        vid_mode = 1;
        base_we = n_we;
        base_rise = n_wait_rise;
        start_load(1'($urandom));
        send(0, 6912, 1'b1);
        end_load();
        chk("cont_writes", 32'(n_we - base_we), 32'd6912);
        chk("cont_wait_toggles", 32'(n_wait_rise > base_rise), 32'd1);
        chk("cont_done", 32'(done), 32'd1);

        // Timex hi-colour screen.
        vid_mode = 0;
        pg = 1'($urandom);
        base_we = n_we;
        start_load(pg);
        send(0, 12288, 1'b1);
        end_load();
        chk("hi_writes", 32'(n_we - base_we), 32'd12288);
        chk("hi_attr_addr", 32'(hi_waddr), pg ? 32'h6000 : 32'h2000);
        chk("hi_done", 32'(done), 32'd1);
        chk("hi_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr_loader.md
# scr_loader

VRAM writer paired with the video controller's screen fetch. Accepts a SCREEN$ image streamed from the IO controller's ioctl download channel and writes it into the shared 15-bit VRAM port during slots the video fetch does not occupy. Buffers bytes in a 4-entry FIFO and throttles the source with `ioctl_wait`. Supports standard 6912-byte screens and 12288-byte Timex hi-colour screens.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries of {addr[13:0], data[7:0]}; power of two, minimum 2.
- WAIT_LEVEL, 3, FIFO occupancy at or above which `ioctl_wait` is asserted.

Ports:
- clk_sys  in  1  master clock.
- reset  in  1  reset, synchronous, active-high; clock clk_sys.
- ce_7mn  in  1  7 MHz negative-phase enable; the only cycles on which a VRAM write may be issued.
- vid_slot  in  1  video owns the VRAM port on this ce_7mn (fetch address/data phase); write forbidden.
- page_scr  in  1  target screen page, sampled at download start.
- ioctl_download  in  1  download active; rising edge starts a load, falling edge ends input.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  14  byte offset within image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  source must hold off further strobes.
- vram_we  out  1  write strobe, one clk_sys cycle, coincident with ce_7mn.
- vram_waddr  out  15  {page, offset[13:0]}.
- vram_wdata  out  8  write data.
- busy  out  1  FSM not in IDLE/DONE.
- done  out  1  sticky; load finished with a valid length.
- err  out  1  sticky; out-of-range address, FIFO overflow or short image.

## Operation
- FSM: IDLE -> LOAD on ioctl_download rising edge; LOAD -> DRAIN on falling edge; DRAIN -> DONE when FIFO is empty and the length check has been performed; DONE -> LOAD on the next rising edge. Reset forces IDLE.
- On entry to LOAD: clear done, err, byte count and max offset; latch page_scr into `page_q`; flush the FIFO.
- ioctl_wr in LOAD with ioctl_addr < 12288: push {addr, data}, increment 14-bit count, update max offset. ioctl_addr >= 12288: byte dropped, err set.
- Push when FIFO full (source ignored ioctl_wait): byte dropped, err set, no corruption of queued entries.
- Write issue: on a cycle with ce_7mn=1, vid_slot=0 and FIFO not empty, pop the head and drive vram_we=1, vram_waddr={page_q, addr}, vram_wdata=data for that cycle only. At most one write per ce_7mn.
- Offsets map directly: 0..6143 bitmap, 6144..6911 attributes, 8192..12287 Timex hi-colour attribute plane (offsets 6912..8191 are accepted and written as given).
- Length check at DRAIN exit: count == 6912 or count == 12288 -> done=1; otherwise err=1, done=0.
- ioctl_wait = (occupancy >= WAIT_LEVEL) in LOAD; 0 otherwise.
- Push and pop in the same cycle: occupancy unchanged, both take effect.
- reset mid-load: FIFO flushed, no further vram_we, all outputs to reset values.

## Timing
- Reset values: ioctl_wait=0, vram_we=0, vram_waddr=0, vram_wdata=0, busy=0, done=0, err=0.
- vram_waddr/vram_wdata registered; stable for the vram_we cycle and held afterwards.
- Push-to-write latency: minimum one ce_7mn after the push cycle (byte pushed on a ce_7mn cycle is not written in that same cycle).
- ioctl_wait asserted the cycle after the occupancy-reaching push; deasserted the cycle after occupancy drops below WAIT_LEVEL.
- busy rises the cycle after the ioctl_download rising edge; done/err update on the cycle of DRAIN -> DONE.
- Worst-case drain rate: one byte per free ce_7mn; video fetch consumes at most 4 of every 8 ce_7mn during active display.

## Structure
- Shared package `scr_pkg`: state enum (IDLE, LOAD, DRAIN, DONE), constants SCR_STD_LEN=6912, SCR_HI_LEN=12288, SCR_ATTR_BASE=6144, SCR_HIATTR_BASE=8192.
- One sub-module: `scr_fifo` (synchronous FIFO, push/pop/full/empty/count, flush input). FSM and write issue in `scr_loader`.

## Test plan
- Standard load, vid_slot=0: 6912 sequential bytes, page_scr=1 -> 6912 vram_we pulses, last at waddr 0x5AFF (page 1, offset 0x1AFF); done=1, err=0.
- Fetch contention: vid_slot asserted 4 of every 8 ce_7mn -> no vram_we on any vid_slot cycle; all 6912 bytes written in order; ioctl_wait toggles.
- Hi-colour load: 12288 bytes -> byte at offset 8192 written to waddr {page,0x2000}; done=1.
- Short image: 100 bytes then download falls -> 100 writes, err=1, done=0.
- Out-of-range/overflow: ioctl_addr=12288 strobe -> no write, err=1; 5 strobes ignoring ioctl_wait with vid_slot=1 -> 4 kept, err=1.
- Reset after 50 bytes with 3 queued -> no further vram_we; busy=0, ioctl_wait=0; new load then succeeds with done=1.
